ddr2_line_server: RTL



---
 rtl/ddr2_line_server_if.sv | 23 ++
 rtl/ddr2_line_server.sv | 137 +++++++++++++
 2 files changed

// File: rtl/ddr2_line_server_if.sv
// ddr2_line_server_if: DDR2-side line bus between the data cache (master)
// and the line server (slave). Byte address, request strobes, 128-bit write
// line in; registered 128-bit read line, completion pulse and sticky
// protocol-error flag out.
interface ddr2_line_server_if;
  logic [26:0]  ddr2_addr;
  logic         ddr2_enable;
  logic         ddr2_read;
  logic [127:0] ddr2_wdata;
  logic [127:0] ddr2_data;
  logic         ddr2_available;
  logic         proto_err;

  modport master (
    output ddr2_addr, ddr2_enable, ddr2_read, ddr2_wdata,
    input  ddr2_data, ddr2_available, proto_err
  );

  modport slave (
    input  ddr2_addr, ddr2_enable, ddr2_read, ddr2_wdata,
    output ddr2_data, ddr2_available, proto_err
  );
endinterface

// File: rtl/ddr2_line_server.sv
// ddr2_line_server: line-granular memory responder for the cache's DDR2 side.
// Writes are posted into the backing array at their accepting edge; reads
// are accepted in IDLE, count down an effective latency in BUSY, fetch the
// line at completion and pulse ddr2_available for the single RESP cycle.
// Optional feature macro: DDR2_SRV_RANDLAT_EN adds 0..7 cycles of
// pseudo-random extra read latency from a free-running 16-bit LFSR.
module ddr2_line_server #(
  parameter int LATENCY    = 4,
  parameter int LINES_LOG2 = 10
) (
  input  logic               clk,
  input  logic               rst,
  ddr2_line_server_if.slave  bus
);

  localparam int CNT_W = 9;  // LATENCY up to 255 plus 7 random cycles

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LINES_LOG2-1:0]   idx_q, idx_d;
  logic [127:0]            data_q, data_d;
  logic                    avail_q, avail_d;
  logic                    err_q, err_d;
  logic                    mem_we;
  logic [LINES_LOG2-1:0]   req_idx;
  logic [CNT_W-1:0]        eff_lat;

  // Backing array; deliberately not reset so a reset never disturbs contents.
  logic [127:0] mem [0:(1<<LINES_LOG2)-1];

  // Offset bits and bits above the index alias onto the same line.
  assign req_idx = bus.ddr2_addr[LINES_LOG2+3:4];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ddr2_addr[26:LINES_LOG2+4], bus.ddr2_addr[3:0]};

`ifdef DDR2_SRV_RANDLAT_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11, advancing every clock.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign eff_lat = CNT_W'(LATENCY) + {{(CNT_W-3){1'b0}}, lfsr_q[2:0]};
`else
  assign eff_lat = CNT_W'(LATENCY);
`endif

  // Next-state, counter, response and error logic of the request FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    avail_d = 1'b0;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ddr2_enable) begin
          if (bus.ddr2_read) begin
            idx_d   = req_idx;
            cnt_d   = eff_lat;
            state_d = BUSY;
          end else begin
            mem_we = ~rst;
          end
        end
      end
      BUSY: begin
        // The cache keeps the same read request asserted while waiting;
        // anything else is a protocol violation and any write is dropped.
        if (bus.ddr2_enable && (!bus.ddr2_read || (req_idx != idx_q))) begin
          err_d = 1'b1;
        end
        if (cnt_q == CNT_W'(1)) begin
          // Array is read at completion so a write just before the read is seen.
          data_d  = mem[idx_q];
          avail_d = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control and output registers; reset aborts any outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end

  // Posted line writes land in the backing array at the accepting edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_idx] <= bus.ddr2_wdata;
  end

  assign bus.ddr2_data      = data_q;
  assign bus.ddr2_available = avail_q;
  assign bus.proto_err      = err_q;

endmodule
